// File: rtl/dds_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel DDS.
package dds_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } dds_state_e;

  // Quadrant of the full phase circle, taken from the top two phase bits.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_e;

  // Quarter-wave table entry idx: round(A * sin(pi/2 * (idx + 0.5) / 2^lut_addr)),
  // A = 2^(out_width-1) - 1. The half-step offset keeps the table symmetric and
  // avoids a zero entry. Evaluated only at elaboration; sine via Taylor series.
  function automatic int quarter_sine_entry(input int idx, input int lut_addr,
                                            input int out_width);
    real x;
    real term;
    real sum;
    real amp;
    x = 1.5707963267948966 * (real'(idx) + 0.5) / real'(32'sd1 <<< lut_addr);
    term = x;
    sum  = x;
    for (int k = 1; k <= 9; k++) begin
      term = -term * x * x / real'((32'sd2 * k) * (32'sd2 * k + 32'sd1));
      sum  = sum + term;
    end
    amp = real'((32'sd1 <<< (out_width - 1)) - 32'sd1);
    return $rtoi(amp * sum + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude table with a registered, enabled read port.
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int LUT_ADDR  = 6,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [LUT_ADDR-1:0]  addr,
  output logic [OUT_WIDTH-2:0] data
);

  localparam int DEPTH = 32'sd1 <<< LUT_ADDR;

  logic [OUT_WIDTH-2:0] table_s [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam int ENTRY = quarter_sine_entry(i, LUT_ADDR, OUT_WIDTH);
    assign table_s[i] = (OUT_WIDTH-1)'(ENTRY);
  end

  // Registered table read; holds its value while the pipeline is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (en) begin
      data <= table_s[addr];
    end
  end

endmodule

// File: rtl/multi_channel_dds.sv
// Multi-channel DDS: per-channel phase accumulators sharing one quarter-wave
// ROM, emitting a serial signed sample stream under valid/ready.
module multi_channel_dds
  import dds_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 16,
  parameter int LUT_ADDR  = 6,
  parameter int OUT_WIDTH = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            tick,
  input  logic                            sync_clear,
  input  logic [CHANNELS*ACC_WIDTH-1:0]   freq_step,
  input  logic [CHANNELS*ACC_WIDTH-1:0]   phase_offset,
  output logic signed [OUT_WIDTH-1:0]     out_sample,
  output logic [CH_W-1:0]                 out_channel,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            overrun
);

  localparam int AW = ACC_WIDTH;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  logic [AW-1:0] acc_r  [CHANNELS];
  logic [AW-1:0] step_s [CHANNELS];
  logic [AW-1:0] off_s  [CHANNELS];

  dds_state_e          state_r;
  logic [CH_W-1:0]     issue_ch_r;

  logic                s1_valid_r;
  logic [LUT_ADDR-1:0] s1_index_r;
  logic                s1_neg_r;
  logic [CH_W-1:0]     s1_ch_r;
  logic                s1_last_r;
  logic                s2_neg_r;

  logic                advance_s;
  logic                accept_s;
  logic                issue_s;
  logic [AW-1:0]       issue_acc_s;
  logic [AW-1:0]       phase_s;
  quadrant_e           quad_s;
  logic [LUT_ADDR-1:0] addr_raw_s;
  logic [LUT_ADDR-1:0] index_s;
  logic                neg_s;
  logic [AW-LUT_ADDR-3:0] phase_unused_s;
  logic [OUT_WIDTH-2:0] rom_mag_s;
  logic [OUT_WIDTH-1:0] mag_ext_s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign step_s[c] = freq_step[c*AW +: AW];
    assign off_s[c]  = phase_offset[c*AW +: AW];
  end

  assign advance_s = !out_valid || out_ready;
  assign accept_s  = out_valid && out_ready;
  assign issue_s   = (state_r == ST_SCAN) && advance_s;

  // Issue-side phase and quadrant mapping; a same-cycle clear is seen by the issue.
  always_comb begin
    issue_acc_s    = sync_clear ? '0 : acc_r[issue_ch_r];
    phase_s        = issue_acc_s + off_s[issue_ch_r];
    quad_s         = quadrant_e'(phase_s[AW-1 -: 2]);
    addr_raw_s     = phase_s[AW-3 -: LUT_ADDR];
    phase_unused_s = phase_s[AW-LUT_ADDR-3:0];
    case (quad_s)
      QUAD_0: begin index_s = addr_raw_s;  neg_s = 1'b0; end
      QUAD_1: begin index_s = ~addr_raw_s; neg_s = 1'b0; end
      QUAD_2: begin index_s = addr_raw_s;  neg_s = 1'b1; end
      QUAD_3: begin index_s = ~addr_raw_s; neg_s = 1'b1; end
      default: begin index_s = addr_raw_s; neg_s = 1'b0; end
    endcase
  end

  // Scan controller: walks the channels once per tick, flags dropped ticks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      issue_ch_r <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= tick && (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (tick) begin
            state_r    <= ST_SCAN;
            issue_ch_r <= '0;
            busy       <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (advance_s) begin
            if (issue_ch_r == LAST_CH) begin
              state_r <= ST_DRAIN;
            end else begin
              issue_ch_r <= issue_ch_r + CH_W'(32'd1);
            end
          end
        end
        ST_DRAIN: begin
          if (accept_s && out_last) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage pipeline (issue -> ROM/output); everything holds while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r  <= 1'b0;
      s1_index_r  <= '0;
      s1_neg_r    <= 1'b0;
      s1_ch_r     <= '0;
      s1_last_r   <= 1'b0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_last    <= 1'b0;
      s2_neg_r    <= 1'b0;
    end else if (advance_s) begin
      s1_valid_r  <= issue_s;
      s1_index_r  <= index_s;
      s1_neg_r    <= neg_s;
      s1_ch_r     <= issue_ch_r;
      s1_last_r   <= issue_s && (issue_ch_r == LAST_CH);
      out_valid   <= s1_valid_r;
      out_channel <= s1_ch_r;
      out_last    <= s1_valid_r && s1_last_r;
      s2_neg_r    <= s1_neg_r;
    end
  end

  // Phase accumulators: clear wins over the acceptance increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) acc_r[c] <= '0;
    end else if (sync_clear) begin
      for (int c = 0; c < CHANNELS; c++) acc_r[c] <= '0;
    end else if (accept_s) begin
      acc_r[out_channel] <= acc_r[out_channel] + step_s[out_channel];
    end
  end

  quarter_sine_rom #(
    .LUT_ADDR  (LUT_ADDR),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_rom (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (advance_s),
    .addr    (s1_index_r),
    .data    (rom_mag_s)
  );

  // Apply the quadrant sign to the registered ROM magnitude.
  always_comb begin
    mag_ext_s = {1'b0, rom_mag_s};
    if (s2_neg_r) begin
      out_sample = -mag_ext_s;
    end else begin
      out_sample = mag_ext_s;
    end
  end

endmodule
